// File: rtl/count_step_decoder.sv
// count_step_decoder: watches the count bus of an up/down counter and rebuilds
// the +/-1 stepping that produced it. Reports step, direction and wrap pulses,
// keeps a signed running position, and latches a sticky fault on illegal jumps.
// Optional macro COUNT_STEP_DECODER_SYNC_EN adds a two-flop input synchronizer
// on count_in/sample_en for counters clocked from a foreign domain.
module count_step_decoder #(
    parameter int unsigned CW = 3,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_en,
    input  logic [CW-1:0] count_in,
    input  logic          clear,
    output logic          step,
    output logic          dir,
    output logic          wrap,
    output logic          err,
    output logic          fault,
    output logic [PW-1:0] position
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    localparam logic [CW-1:0] CntMax = {CW{1'b1}};
    localparam logic [CW-1:0] CntOne = CW'(1);

    // Decode-side view of the input sample (direct or synchronized)
    logic [CW-1:0] s_count;
    logic          s_en;

`ifdef COUNT_STEP_DECODER_SYNC_EN
    logic [CW-1:0] cnt_s1_q, cnt_s2_q;
    logic          en_s1_q, en_s2_q;

    // Two-flop synchronizer; clear drops any qualifier still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_s1_q <= '0;
            cnt_s2_q <= '0;
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
        end else begin
            cnt_s1_q <= count_in;
            cnt_s2_q <= cnt_s1_q;
            en_s1_q  <= sample_en & ~clear;
            en_s2_q  <= en_s1_q & ~clear;
        end
    end

    assign s_count = cnt_s2_q;
    assign s_en    = en_s2_q;
`else
    assign s_count = count_in;
    assign s_en    = sample_en;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] last_q, last_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          fault_q, fault_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [CW-1:0] delta;

    // Modular distance from the reference sample; wraps naturally at CW bits
    assign delta = s_count - last_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            fault_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode; pulses default low so they last one cycle per sample
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (clear) begin
            // Clear wins over a same-cycle sample, which is discarded
            state_d = StIdle;
            pos_d   = '0;
            dir_d   = 1'b0;
            fault_d = 1'b0;
        end else if (s_en) begin
            unique case (state_q)
                StIdle: begin
                    last_d  = s_count;
                    state_d = StTrack;
                end
                StTrack: begin
                    last_d = s_count;
                    if (delta == '0) begin
                        // No movement
                    end else if (delta == CntOne) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q + PW'(1);
                        wrap_d = (last_q == CntMax);
                    end else if (delta == CntMax) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q - PW'(1);
                        wrap_d = (last_q == '0);
                    end else begin
                        err_d   = 1'b1;
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
                StFault: begin
                    // Frozen until clear
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign wrap     = wrap_q;
    assign err      = err_q;
    assign fault    = fault_q;
    assign position = pos_q;

endmodule

// File: tb/tb_count_step_decoder.sv
// Scoreboard bench for count_step_decoder (CW=3, PW=4). Directed vectors carry
// hand-computed expected outputs; a monitor compares them on the falling edge.
module tb_count_step_decoder;

    localparam int CW = 3;
    localparam int PW = 4;
`ifdef COUNT_STEP_DECODER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_en;
    logic [CW-1:0] count_in;
    logic          clear;
    logic          step, dir, wrap, err, fault;
    logic [PW-1:0] position;

    count_step_decoder #(.CW(CW), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(sample_en),
        .count_in (count_in),
        .clear    (clear),
        .step     (step),
        .dir      (dir),
        .wrap     (wrap),
        .err      (err),
        .fault    (fault),
        .position (position)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {step, dir, wrap, err, fault, position}
    logic [8:0] obs;
    assign obs = {step, dir, wrap, err, fault, position};

    typedef struct {
        int         id;
        int unsigned due;
        logic [8:0] exp;
    } exp_t;

    typedef struct {
        logic          en;
        logic          clr;
        logic [CW-1:0] cnt;
        logic [8:0]    exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got step=%b dir=%b wrap=%b err=%b fault=%b pos=%0d, want step=%b dir=%b wrap=%b err=%b fault=%b pos=%0d",
                      name, act[8], act[7], act[6], act[5], act[4], act[3:0],
                      req[8], req[7], req[6], req[5], req[4], req[3:0]);
    endtask

    task automatic add(input logic en, input logic clr, input int cnt, input logic s,
                       input logic d, input logic w, input logic e, input logic f, input int p);
        vec_t v;
        v.en  = en;
        v.clr = clr;
        v.cnt = CW'(cnt);
        v.exp = {s, d, w, e, f, 4'(p)};
        vecs.push_back(v);
    endtask

    // Monitor: pop every expectation whose due edge has passed and compare
    exp_t cur;
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                cur = sb.pop_front();
                check($sformatf("vec%0d", cur.id), obs, cur.exp);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b0;
        count_in  = '0;
        clear     = 1'b0;

        // Up through a full lap: single wrap on 7->0
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c < 8; c++) add(1, 0, c, 1, 0, 0, 0, 0, c);
        add(1, 0, 0, 1, 0, 1, 0, 0, 8);
        add(1, 0, 1, 1, 0, 0, 0, 0, 9);
        add(1, 0, 2, 1, 0, 0, 0, 0, 10);
        // Down from 2: wrap only on 0->7
        add(1, 0, 1, 1, 1, 0, 0, 0, 9);
        add(1, 0, 0, 1, 1, 0, 0, 0, 8);
        add(1, 0, 7, 1, 1, 1, 0, 0, 7);
        add(1, 0, 6, 1, 1, 0, 0, 0, 6);
        // Idle and repeated sample: nothing moves
        add(0, 0, 6, 0, 1, 0, 0, 0, 6);
        add(1, 0, 6, 0, 1, 0, 0, 0, 6);
        add(1, 0, 5, 1, 1, 0, 0, 0, 5);
        add(1, 0, 4, 1, 1, 0, 0, 0, 4);
        add(1, 0, 3, 1, 1, 0, 0, 0, 3);
        // Illegal jump 3->5, then frozen
        add(1, 0, 5, 0, 1, 0, 1, 1, 3);
        add(1, 0, 6, 0, 1, 0, 0, 1, 3);
        add(1, 0, 7, 0, 1, 0, 0, 1, 3);
        // Clear, then first sample gives no step
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 0, 0, 0, 0, 0);
        add(0, 0, 4, 0, 0, 0, 0, 0, 0);
        add(1, 0, 5, 1, 0, 0, 0, 0, 1);
        // Clear with a same-cycle sample: sample discarded, 7 is a fresh reference
        add(1, 1, 6, 0, 0, 0, 0, 0, 0);
        add(1, 0, 7, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0, 1);
        for (int c = 1; c < 7; c++) add(1, 0, c, 1, 0, 0, 0, 0, c + 1);
        // Eight more up steps: position 7 -> 15 (-1 in 4 bits), no error
        for (int k = 0; k < 8; k++)
            add(1, 0, (7 + k) % 8, 1, 0, ((7 + k) % 8) == 0, 0, 0, 8 + k);

        // Outputs held at reset values while rst_n is low
        @(posedge clk); #1;
        sb.push_back('{id: -1, due: cyc, exp: 9'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            sample_en = vecs[i].en;
            clear     = vecs[i].clr;
            count_in  = vecs[i].cnt;
            sb.push_back('{id: i, due: cyc + LAT, exp: vecs[i].exp});
            @(posedge clk); #1;
            sample_en = 1'b0;
            clear     = 1'b0;
            for (int p = 1; p < LAT; p++) begin
                @(posedge clk); #1;
            end
        end
        sample_en = 1'b0;
        clear     = 1'b0;

        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(negedge clk); #1;
        end
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d expectations pending, want 0", sb.size());
        end

        // Asynchronous reset mid-stream: outputs drop with no clock edge
        @(negedge clk); #1;
        sample_en = 1'b1;
        count_in  = 3'd7;
        rst_n     = 1'b0;
        #1;
        check("async_reset", obs, 9'd0);
        sample_en = 1'b0;
        #2;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
